// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit owning the architectural HI/LO registers.
// Works on operand magnitudes (shift-add / restoring divide) and applies signs in a final fix-up cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_control,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;

    // The most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v) + WIDTH'(1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v) + WIDTH'(1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v) + (2*WIDTH)'(1) : v;
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] mult_step_s;
    logic [WIDTH+1:0]   diff_s;
    logic [2*WIDTH-1:0] div_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // One iteration of either algorithm plus the signed results seen in the fix-up cycle.
    // acc_r holds {partial, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        accept_s    = start && ((alu_control == OP_MULT) || (alu_control == OP_DIV));
        mag_a_s     = magnitude(op_a);
        mag_b_s     = magnitude(op_b);
        add_s       = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mult_step_s = {add_s, acc_r[WIDTH-1:1]};
        diff_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {2'b00, opnd_r};
        if (diff_s[WIDTH+1]) begin
            div_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end else begin
            div_step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
        prod_s = cond_neg2(neg_q_r, acc_r);
        quo_s  = div_zero_r ? {WIDTH{1'b1}} : cond_neg(neg_q_r, acc_r[WIDTH-1:0]);
        rem_s  = cond_neg(neg_r_r, acc_r[2*WIDTH-1:WIDTH]);
    end

    // Control FSM, iteration datapath and HI/LO register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            opnd_r     <= '0;
            acc_r      <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_div_r   <= (alu_control == OP_DIV);
                        neg_q_r    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_r_r    <= op_a[WIDTH-1];
                        div_zero_r <= (op_b == '0);
                        opnd_r     <= (alu_control == OP_DIV) ? mag_b_s : mag_a_s;
                        acc_r      <= {{WIDTH{1'b0}}, (alu_control == OP_DIV) ? mag_a_s : mag_b_s};
                        cnt_r      <= CW'(WIDTH - 1);
                        busy_r     <= 1'b1;
                        state_r    <= ST_CALC;
                    end else begin
                        if (hi_wr) begin
                            hi_r <= wdata;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (lo_wr) begin
                            lo_r <= wdata;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end
                end
                ST_CALC: begin
                    acc_r <= is_div_r ? div_step_s : mult_step_s;
                    if (cnt_r == '0) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_s;
                        lo_r <= quo_s;
                    end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                    end
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic/latency reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_mult_div_unit;
    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_control;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .alu_control(alu_control), .start(start),
        .op_a(op_a), .op_b(op_b), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo} from plain signed 64-bit / integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa;
        int sb;
        int q;
        int r;
        if (code == 4'b1001) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_busy;
    logic        exp_done;
    logic [63:0] pend;
    int          left;

    // Model: an accepted op yields its result 33 edges later; writes only land while idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_hi <= 32'h0; exp_lo <= 32'h0; exp_busy <= 1'b0; exp_done <= 1'b0;
            left <= 0; pend <= 64'h0;
        end else begin
            exp_done <= 1'b0;
            if (left == 0) begin
                if (start && (alu_control == 4'b1001 || alu_control == 4'b1010)) begin
                    pend     <= ref_result(alu_control, op_a, op_b);
                    left     <= 33;
                    exp_busy <= 1'b1;
                end else begin
                    if (hi_wr) exp_hi <= wdata;
                    if (lo_wr) exp_lo <= wdata;
                end
            end else begin
                left <= left - 1;
                if (left == 1) begin
                    exp_hi   <= pend[63:32];
                    exp_lo   <= pend[31:0];
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("hi", {32'h0, hi}, {32'h0, exp_hi});
        check("lo", {32'h0, lo}, {32'h0, exp_lo});
        check("busy", {63'h0, busy}, {63'h0, exp_busy});
        check("done", {63'h0, done}, {63'h0, exp_done});
    end

    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        alu_control = code; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within 60 cycles at %0t", $time);
        end
    endtask

    int cyc;
    int pulses;

    initial begin
        rst_n = 1'b0; alu_control = 4'h0; start = 1'b0; op_a = 32'h0; op_b = 32'h0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);

        // mult 7 * -3
        issue(4'b1001, 32'h0000_0007, 32'hFFFF_FFFD);
        check("mult_busy_e0", {63'h0, busy}, 64'h1);
        wait_done(cyc);
        check("mult_latency", cyc, 34);
        check("mult_7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // div -7 / 2, then most-negative / -1
        @(negedge clk);
        issue(4'b1010, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(cyc);
        check("div_-7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // divide by zero
        @(negedge clk);
        issue(4'b1010, 32'h0000_0005, 32'h0000_0000);
        wait_done(cyc);
        check("div0_latency", cyc, 34);
        check("div_5/0", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        @(negedge clk);
        check("div0_single_pulse", {63'h0, done}, 64'h0);

        // interference during CALC: 100 / -7 = -14 rem 2
        issue(4'b1010, 32'd100, 32'hFFFF_FFF9);
        repeat (9) @(negedge clk);
        alu_control = 4'b1001; start = 1'b1; hi_wr = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0;
        wait_done(cyc);
        check("div_interfered", {hi, lo}, 64'h0000_0002_FFFF_FFF2);
        @(negedge clk);
        hi_wr = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1 hi_wr = 1'b0;
        check("mthi", {hi, lo}, 64'h0000_1234_FFFF_FFF2);

        // accepted start beats simultaneous writes; then a dual write
        @(negedge clk);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        issue(4'b1001, 32'd3, 32'd4);
        hi_wr = 1'b0; lo_wr = 1'b0;
        wait_done(cyc);
        check("start_priority", {hi, lo}, 64'h0000_0000_0000_000C);
        @(negedge clk);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk); #1 hi_wr = 1'b0; lo_wr = 1'b0;
        check("dual_write", {hi, lo}, 64'h0000_ABCD_0000_ABCD);

        // reset in the middle of a mult
        @(negedge clk);
        issue(4'b1001, 32'h0001_2345, 32'h0000_0777);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'h0);
        check("midrst_busy", {62'h0, busy, done}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("no_done_after_rst", pulses, 0);

        // non mult/div code is ignored
        issue(4'b0010, 32'd9, 32'd9);
        check("add_ignored", {63'h0, busy}, 64'h0);

        // back-to-back: second op issued in the done cycle
        @(negedge clk);
        issue(4'b1001, 32'd6, 32'd7);
        wait_done(cyc);
        check("b2b_first", {hi, lo}, 64'h0000_0000_0000_002A);
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_accept", {63'h0, busy}, 64'h1);
        wait_done(cyc);
        check("b2b_latency", cyc, 34);
        check("b2b_second", {hi, lo}, 64'h0000_0000_0000_0001);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
